// File: rtl/stacktr_ctrl.sv
// stacktr_ctrl: call/return stack-trace buffer sequencer.
// Pushes {pc,npc} on calls, pops on returns, and serves debug reads of
// entries by depth index through a single write port and one read port.
// Optional feature macro: STACKTR_WRAP_EN. When it is defined, a push into
// a full buffer overwrites the oldest entry. When it is not defined, such a
// push is dropped. In both cases the sticky overflow flag is set.
module stacktr_ctrl #(
    parameter int unsigned abits = 5,
    parameter int unsigned xlen  = 64
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic                i_e_call,
    input  logic                i_e_ret,
    input  logic [xlen-1:0]     i_e_pc,
    input  logic [xlen-1:0]     i_e_npc,
    input  logic                i_flush,
    input  logic                i_dbg_req,
    output logic                o_dbg_ready,
    input  logic [abits-1:0]    i_dbg_idx,
    output logic                o_dbg_resp_valid,
    input  logic                i_dbg_resp_ready,
    output logic [2*xlen-1:0]   o_dbg_resp_data,
    output logic                o_dbg_resp_err,
    output logic [abits:0]      o_depth,
    output logic                o_ovf,
    output logic                o_we,
    output logic [abits-1:0]    o_waddr,
    output logic [2*xlen-1:0]   o_wdata,
    output logic [abits-1:0]    o_raddr,
    input  logic [2*xlen-1:0]   i_rdata
);

    localparam int unsigned AW     = abits;
    localparam int unsigned DW     = 2 * xlen;
    localparam int unsigned DEPTHW = abits + 1;
    localparam int unsigned SIZE   = 2 ** abits;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RESP = 2'd2
    } dbg_state_e;

    // Stack state
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [DEPTHW-1:0] depth_q, depth_d;
    logic              ovf_q, ovf_d;
    logic              full, empty;
    logic              we_c;
    logic [AW-1:0]     waddr_c;

    // Debug read state
    dbg_state_e        state_q, state_d;
    logic              accept;
    logic              dbg_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic              err_lat_q;
    logic              resp_first_q;
    logic [AW-1:0]     raddr_q;
    logic [DW-1:0]     data_q;
    logic [DW-1:0]     resp_data_c;

    assign full  = (depth_q == DEPTHW'(SIZE));
    assign empty = (depth_q == '0);

    // Push/pop/replace/flush decode; the write port is driven combinationally
    always_comb begin
        wptr_d  = wptr_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        we_c    = 1'b0;
        waddr_c = wptr_q;
        if (i_flush) begin
            wptr_d  = '0;
            depth_d = '0;
            ovf_d   = 1'b0;
        end else if (i_e_call && i_e_ret) begin
            // Replace top; on an empty stack this degenerates to a single push
            we_c = 1'b1;
            if (empty) begin
                waddr_c = wptr_q;
                wptr_d  = wptr_q + AW'(1);
                depth_d = DEPTHW'(1);
            end else begin
                waddr_c = wptr_q - AW'(1);
            end
        end else if (i_e_call) begin
            if (!full) begin
                we_c    = 1'b1;
                wptr_d  = wptr_q + AW'(1);
                depth_d = depth_q + DEPTHW'(1);
            end else begin
                ovf_d = 1'b1;
`ifdef STACKTR_WRAP_EN
                we_c   = 1'b1;
                wptr_d = wptr_q + AW'(1);
`endif
            end
        end else if (i_e_ret && !empty) begin
            wptr_d  = wptr_q - AW'(1);
            depth_d = depth_q - DEPTHW'(1);
        end
    end

    // Stack pointer, depth and sticky overflow registers
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wptr_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_we    = we_c;
    assign o_waddr = waddr_c;
    assign o_wdata = {i_e_pc, i_e_npc};
    assign o_depth = depth_q;
    assign o_ovf   = ovf_q;

    assign accept = (state_q == ST_IDLE) && dbg_ready_q && i_dbg_req;

    // Debug FSM state register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Debug FSM next state: accept, wait one RAM cycle, hold response until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RD;
            ST_RD:   state_d = ST_RESP;
            ST_RESP: if (i_dbg_resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response data: live RAM data on the first RESP cycle, captured copy afterwards
    always_comb begin
        resp_data_c = data_q;
        if (resp_first_q) begin
            resp_data_c = err_lat_q ? '0 : i_rdata;
        end
    end

    // Debug handshake, latched address/error and response holding registers
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            dbg_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            err_lat_q    <= 1'b0;
            resp_first_q <= 1'b0;
            raddr_q      <= '0;
            data_q       <= '0;
        end else begin
            dbg_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
            resp_err_q   <= (state_d == ST_RESP) ? err_lat_q : 1'b0;
            resp_first_q <= (state_q == ST_RD);
            data_q       <= ((state_q == ST_RESP) && (state_d == ST_RESP)) ? resp_data_c : '0;
            if (accept) begin
                raddr_q   <= wptr_q - AW'(1) - i_dbg_idx;
                err_lat_q <= (DEPTHW'(i_dbg_idx) >= depth_q);
            end
        end
    end

    assign o_dbg_ready      = dbg_ready_q;
    assign o_dbg_resp_valid = resp_valid_q;
    assign o_dbg_resp_err   = resp_err_q;
    assign o_dbg_resp_data  = resp_data_c;
    assign o_raddr          = raddr_q;

endmodule

// File: tb/tb_stacktr_ctrl.sv
// Directed bench for stacktr_ctrl with a write-first, 1-cycle-latency RAM model.
module tb_stacktr_ctrl;

    logic          i_clk = 1'b0;
    logic          i_nrst;
    logic          i_e_call, i_e_ret, i_flush;
    logic [63:0]   i_e_pc, i_e_npc;
    logic          i_dbg_req;
    logic          o_dbg_ready;
    logic [4:0]    i_dbg_idx;
    logic          o_dbg_resp_valid;
    logic          i_dbg_resp_ready;
    logic [127:0]  o_dbg_resp_data;
    logic          o_dbg_resp_err;
    logic [5:0]    o_depth;
    logic          o_ovf;
    logic          o_we;
    logic [4:0]    o_waddr;
    logic [127:0]  o_wdata;
    logic [4:0]    o_raddr;
    logic [127:0]  i_rdata;

    logic [127:0]  mem [32];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    stacktr_ctrl #(.abits(5), .xlen(64)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_e_call(i_e_call), .i_e_ret(i_e_ret), .i_e_pc(i_e_pc), .i_e_npc(i_e_npc),
        .i_flush(i_flush),
        .i_dbg_req(i_dbg_req), .o_dbg_ready(o_dbg_ready), .i_dbg_idx(i_dbg_idx),
        .o_dbg_resp_valid(o_dbg_resp_valid), .i_dbg_resp_ready(i_dbg_resp_ready),
        .o_dbg_resp_data(o_dbg_resp_data), .o_dbg_resp_err(o_dbg_resp_err),
        .o_depth(o_depth), .o_ovf(o_ovf),
        .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .o_raddr(o_raddr), .i_rdata(i_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Write-first synchronous RAM
    always @(posedge i_clk) begin
        if (o_we) mem[o_waddr] <= o_wdata;
        i_rdata <= (o_we && (o_waddr == o_raddr)) ? o_wdata : mem[o_raddr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ent(input logic [63:0] pc);
        return {pc, pc + 64'h1000};
    endfunction

    // One cycle of execute-stage activity, launched at a falling edge
    task automatic step(input logic call, input logic ret, input logic flush, input logic [63:0] pc);
        i_e_call = call; i_e_ret = ret; i_flush = flush;
        i_e_pc = pc; i_e_npc = pc + 64'h1000;
        @(negedge i_clk);
        i_e_call = 1'b0; i_e_ret = 1'b0; i_flush = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!o_dbg_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, "_ready"}, 128'(o_dbg_ready), 128'(1));
    endtask

    task automatic dbg_read(input string tag, input logic [4:0] idx,
                            input logic [127:0] exp_data, input logic exp_err);
        wait_ready(tag);
        i_dbg_req = 1'b1; i_dbg_idx = idx;
        @(negedge i_clk);
        i_dbg_req = 1'b0;
        chk({tag, "_rd_valid"}, 128'(o_dbg_resp_valid), 128'(0));
        @(negedge i_clk);
        chk({tag, "_valid"}, 128'(o_dbg_resp_valid), 128'(1));
        chk({tag, "_data"}, o_dbg_resp_data, exp_data);
        chk({tag, "_err"}, 128'(o_dbg_resp_err), 128'(exp_err));
        i_dbg_resp_ready = 1'b1;
        @(negedge i_clk);
        i_dbg_resp_ready = 1'b0;
        chk({tag, "_done"}, 128'(o_dbg_resp_valid), 128'(0));
    endtask

    initial begin
        i_nrst = 1'b0;
        i_e_call = 1'b0; i_e_ret = 1'b0; i_flush = 1'b0;
        i_e_pc = '0; i_e_npc = '0;
        i_dbg_req = 1'b0; i_dbg_idx = '0; i_dbg_resp_ready = 1'b0;

        // Reset values
        #12;
        chk("rst_depth", 128'(o_depth), 128'(0));
        chk("rst_ovf", 128'(o_ovf), 128'(0));
        chk("rst_ready", 128'(o_dbg_ready), 128'(0));
        chk("rst_valid", 128'(o_dbg_resp_valid), 128'(0));
        chk("rst_err", 128'(o_dbg_resp_err), 128'(0));
        chk("rst_data", o_dbg_resp_data, 128'(0));
        chk("rst_raddr", 128'(o_raddr), 128'(0));
        chk("rst_we", 128'(o_we), 128'(0));
        @(negedge i_clk);
        i_nrst = 1'b1;

        // Three calls, read most recent
        i_e_call = 1'b1; i_e_pc = 64'h100; i_e_npc = 64'h1100;
        #1;
        chk("push0_we", 128'(o_we), 128'(1));
        chk("push0_waddr", 128'(o_waddr), 128'(0));
        chk("push0_wdata", o_wdata, ent(64'h100));
        @(negedge i_clk);
        i_e_call = 1'b0;
        step(1'b1, 1'b0, 1'b0, 64'h200);
        step(1'b1, 1'b0, 1'b0, 64'h300);
        chk("depth3", 128'(o_depth), 128'(3));
        dbg_read("rd_top", 5'd0, ent(64'h300), 1'b0);

        // One return, then out-of-range and in-range reads
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("depth_pop", 128'(o_depth), 128'(2));
        dbg_read("rd_oob", 5'd2, 128'(0), 1'b1);
        dbg_read("rd_idx1", 5'd1, ent(64'h100), 1'b0);

        // Call and return together replace the top entry
        i_e_call = 1'b1; i_e_ret = 1'b1; i_e_pc = 64'h500; i_e_npc = 64'h1500;
        #1;
        chk("repl_waddr", 128'(o_waddr), 128'(1));
        @(negedge i_clk);
        i_e_call = 1'b0; i_e_ret = 1'b0;
        chk("repl_depth", 128'(o_depth), 128'(2));
        dbg_read("rd_repl", 5'd0, ent(64'h500), 1'b0);

        // Fill past capacity with pc = k*4
        step(1'b0, 1'b0, 1'b1, 64'h0);
        chk("flush_depth", 128'(o_depth), 128'(0));
        for (int k = 0; k < 32; k++) step(1'b1, 1'b0, 1'b0, 64'(k * 4));
        chk("full_ovf_clear", 128'(o_ovf), 128'(0));
        i_e_call = 1'b1; i_e_pc = 64'h80; i_e_npc = 64'h1080;
        #1;
`ifdef STACKTR_WRAP_EN
        chk("full_push_we", 128'(o_we), 128'(1));
`else
        chk("full_push_we", 128'(o_we), 128'(0));
`endif
        @(negedge i_clk);
        i_e_call = 1'b0;
        chk("full_depth", 128'(o_depth), 128'(32));
        chk("full_ovf", 128'(o_ovf), 128'(1));
`ifdef STACKTR_WRAP_EN
        dbg_read("rd_wrap", 5'd31, ent(64'h4), 1'b0);
`else
        dbg_read("rd_drop", 5'd0, ent(64'h7C), 1'b0);
`endif

        // Pop down to 5, then flush with a simultaneous call
        for (int k = 0; k < 27; k++) step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("depth5", 128'(o_depth), 128'(5));
        chk("depth5_ovf", 128'(o_ovf), 128'(1));
        i_flush = 1'b1; i_e_call = 1'b1; i_e_pc = 64'h900; i_e_npc = 64'h1900;
        #1;
        chk("flush_call_we", 128'(o_we), 128'(0));
        @(negedge i_clk);
        i_flush = 1'b0; i_e_call = 1'b0;
        chk("flush_call_depth", 128'(o_depth), 128'(0));
        chk("flush_call_ovf", 128'(o_ovf), 128'(0));
        i_e_ret = 1'b1;
        #1;
        chk("ret_empty_we", 128'(o_we), 128'(0));
        @(negedge i_clk);
        i_e_ret = 1'b0;
        chk("ret_empty_depth", 128'(o_depth), 128'(0));

        // Stalled response stays stable across a same-address overwrite
        step(1'b1, 1'b0, 1'b0, 64'hA00);
        wait_ready("stall");
        i_dbg_req = 1'b1; i_dbg_idx = 5'd0;
        @(negedge i_clk);
        i_dbg_req = 1'b0;
        @(negedge i_clk);
        for (int c = 0; c < 4; c++) begin
            chk("stall_valid", 128'(o_dbg_resp_valid), 128'(1));
            chk("stall_data", o_dbg_resp_data, ent(64'hA00));
            if (c == 1) step(1'b1, 1'b1, 1'b0, 64'hB00);
            else @(negedge i_clk);
        end
        chk("stall_valid_end", 128'(o_dbg_resp_valid), 128'(1));
        chk("stall_data_end", o_dbg_resp_data, ent(64'hA00));

        // Reset in the middle of a response
        i_nrst = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(o_dbg_resp_valid), 128'(0));
        chk("rst_mid_data", o_dbg_resp_data, 128'(0));
        chk("rst_mid_depth", 128'(o_depth), 128'(0));
        @(negedge i_clk);
        i_nrst = 1'b1;
        @(negedge i_clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
